// File: rtl/i2s_async_src_buf_pkg.sv
// Shared encodings and helpers for the I2S async source buffer.
// State values are fixed so debug/trace tooling can decode them directly.
package i2s_async_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_REL  = 2'b10
  } state_t;

  // Two-phase mode has only one waiting state; it shares the REQ encoding.
  localparam state_t ST_WAIT = ST_REQ;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/i2s_async_src_buf_if.sv
// Bus bundle for i2s_async_src_buf: local-domain push side plus async launch side.
interface i2s_async_src_buf_if
  import i2s_async_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int LW = ptr_w(DEPTH);

  // Push side: a word transfers on a clk edge where data_in_valid && data_in_ready;
  // data_in must be stable while valid is high. Launch side is a req/ack pair that
  // crosses clock domains, with data_out held constant for the whole transfer.
  logic [WIDTH-1:0] data_in;
  logic             data_in_valid;
  logic             data_in_ready;
  logic [WIDTH-1:0] data_out;
  logic             data_out_valid;
  logic             data_out_ack;
  logic [LW-1:0]    fifo_level;

  modport slave (
    input  data_in, data_in_valid, data_out_ack,
    output data_in_ready, data_out, data_out_valid, fifo_level
  );

  modport master (
    output data_in, data_in_valid, data_out_ack,
    input  data_in_ready, data_out, data_out_valid, fifo_level
  );

endinterface

// File: rtl/i2s_async_src_buf_sync_chain.sv
// Multi-flop synchroniser for the asynchronous acknowledge; clears to 0 on reset.
module i2s_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[STAGES-2:0], din};
  end

  assign dout = r_sync[STAGES-1];

endmodule

// File: rtl/i2s_async_src_buf.sv
// Buffered CDC source: FIFO of DEPTH words launched one at a time over req/ack.
// Define I2S_ASYNC_SRC_TOGGLE_EN for the two-phase (toggle) handshake.
module i2s_async_src_buf
  import i2s_async_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  i2s_async_src_buf_if.slave   bus,
  output state_t               o_dbg_state
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [WIDTH-1:0] r_data_out;
  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_launch;
  logic             w_ack_sync;

  i2s_sync_chain #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.data_out_ack),
    .dout (w_ack_sync)
  );

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  // Ready comes only from registered pointers, so a same-cycle pop cannot admit a push.
  assign w_push  = bus.data_in_valid && !w_full;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= bus.data_in;
  end

`ifdef I2S_ASYNC_SRC_TOGGLE_EN
  logic r_tog;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_tog <= 1'b0;
    else if (w_launch) r_tog <= ~r_tog;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    case (r_state)
      ST_IDLE: if (!w_empty) begin
        w_launch    = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: if (w_ack_sync == r_tog) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.data_out_valid = r_tog;
`else
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    case (r_state)
      ST_IDLE: if (!w_empty) begin
        w_launch    = 1'b1;
        w_state_nxt = ST_REQ;
      end
      ST_REQ:  if (w_ack_sync)  w_state_nxt = ST_REL;
      ST_REL:  if (!w_ack_sync) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.data_out_valid = (r_state == ST_REQ);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_data_out <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_launch) begin
        r_rptr     <= r_rptr + 1'b1;
        r_data_out <= r_mem[r_rptr[AW-1:0]];
      end
    end
  end

  assign bus.data_in_ready = !w_full;
  assign bus.data_out      = r_data_out;
  assign bus.fifo_level    = r_wptr - r_rptr;
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_i2s_async_src_buf.sv
// Directed bench for i2s_async_src_buf; honours I2S_ASYNC_SRC_TOGGLE_EN like the RTL.
module tb_i2s_async_src_buf;
  import i2s_async_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t dbg_state;
  logic   auto_en = 1'b0;
  logic   man_ack = 1'b0;
  logic   resp_ack;
  int     resp_cnt;
  int     ack_dly = 1;
  int     n_tests = 0;
  int     n_fail  = 0;
  int     max_lvl = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] got_q[$];

  i2s_async_src_buf_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  i2s_async_src_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  assign bus.data_out_ack = auto_en ? resp_ack : man_ack;

  // ---------------- destination responder ----------------
  always @(posedge clk or posedge rst) begin
    if (rst || !auto_en) begin
      resp_ack <= 1'b0;
      resp_cnt <= 0;
    end else begin
`ifdef I2S_ASYNC_SRC_TOGGLE_EN
      if (bus.data_out_valid != resp_ack) begin
        if (resp_cnt >= ack_dly) begin
          resp_ack <= bus.data_out_valid;
          got_q.push_back(bus.data_out);
          resp_cnt <= 0;
          ack_dly = $urandom_range(0, 3);
        end else resp_cnt <= resp_cnt + 1;
      end
`else
      if (bus.data_out_valid && !resp_ack) begin
        if (resp_cnt >= ack_dly) begin
          resp_ack <= 1'b1;
          got_q.push_back(bus.data_out);
          resp_cnt <= 0;
          ack_dly = $urandom_range(0, 3);
        end else resp_cnt <= resp_cnt + 1;
      end else if (!bus.data_out_valid && resp_ack) begin
        if (resp_cnt >= ack_dly) begin
          resp_ack <= 1'b0;
          resp_cnt <= 0;
          ack_dly = $urandom_range(0, 3);
        end else resp_cnt <= resp_cnt + 1;
      end
`endif
    end
  end

  always @(negedge clk) begin
    if (!rst && int'(bus.fifo_level) > max_lvl) max_lvl = int'(bus.fifo_level);
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_drain(input int n);
    int c;
    c = 0;
    while (c < 2000 && !(got_q.size() == n && dbg_state == ST_IDLE && bus.fifo_level == 0)) begin
      step(1);
      c++;
    end
    chk("drain_in_time", (c < 2000), 1'b1);
  endtask

  task automatic score(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) chk(tag, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int  pushed;
    logic will;
    bus.data_in       = '0;
    bus.data_in_valid = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;

    // reset / idle
    chk("rst_ready", bus.data_in_ready, 1'b1);
    chk("rst_level", bus.fifo_level, 0);
    chk("rst_valid", bus.data_out_valid, 1'b0);
    chk("rst_state", dbg_state, ST_IDLE);
    for (int i = 0; i < 20; i++) begin
      chk("idle_data_out", bus.data_out, 0);
      step(1);
    end

`ifdef I2S_ASYNC_SRC_TOGGLE_EN
    // two-phase: four words, toggles 1,0,1,0
    begin
      logic [WIDTH-1:0] w[4];
      w[0] = 32'h1111_0001; w[1] = 32'h2222_0002; w[2] = 32'h3333_0003; w[3] = 32'h4444_0004;
      for (int i = 0; i < 4; i++) begin
        bus.data_in = w[i];
        bus.data_in_valid = 1'b1;
        step(1);
      end
      bus.data_in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
        chk("tog_valid", bus.data_out_valid, (k % 2 == 0) ? 1'b1 : 1'b0);
        chk("tog_data", bus.data_out, w[k]);
        man_ack = bus.data_out_valid;
        step(3);
        chk("tog_idle", dbg_state, ST_IDLE);
        chk("tog_hold", bus.data_out, w[k]);
        step(1);
      end
      chk("tog_final_valid", bus.data_out_valid, 1'b0);
      chk("tog_final_state", dbg_state, ST_IDLE);
    end
`else
    // single word, ack raised 3 cycles after valid
    bus.data_in = 32'hA5A5_0001;
    bus.data_in_valid = 1'b1;
    step(1);
    bus.data_in_valid = 1'b0;
    chk("single_valid_e0", bus.data_out_valid, 1'b0);
    step(1);
    chk("single_valid_e1", bus.data_out_valid, 1'b1);
    chk("single_data_e1", bus.data_out, 32'hA5A5_0001);
    chk("single_state_req", dbg_state, ST_REQ);
    step(3);
    man_ack = 1'b1;
    step(2);
    chk("single_valid_sync", bus.data_out_valid, 1'b1);
    step(1);
    chk("single_valid_fall", bus.data_out_valid, 1'b0);
    chk("single_state_rel", dbg_state, ST_REL);
    man_ack = 1'b0;
    step(2);
    chk("single_state_rel_hold", dbg_state, ST_REL);
    step(1);
    chk("single_state_idle", dbg_state, ST_IDLE);
    chk("single_data_hold", bus.data_out, 32'hA5A5_0001);
`endif

    // fill with destination stalled
    man_ack = 1'b0;
    auto_en = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      bus.data_in = WIDTH'(i);
      bus.data_in_valid = 1'b1;
      chk("fill_ready", bus.data_in_ready, 1'b1);
      exp_q.push_back(WIDTH'(i));
      step(1);
    end
    bus.data_in_valid = 1'b0;
    chk("fill_level", bus.fifo_level, 4);
    chk("fill_full", bus.data_in_ready, 1'b0);
    chk("fill_head", bus.data_out, 1);
    bus.data_in = 32'd6;
    bus.data_in_valid = 1'b1;
    step(3);
    bus.data_in_valid = 1'b0;
    chk("fill_held_level", bus.fifo_level, 4);
    chk("fill_held_ready", bus.data_in_ready, 1'b0);
    auto_en = 1'b1;
    wait_drain(5);
    score("fill_order");

    // wrap-around stream of 37 words
    max_lvl = 0;
    pushed = 0;
    for (int c = 0; c < 3000 && pushed < 37; c++) begin
      bus.data_in = 32'h100 + WIDTH'(pushed);
      bus.data_in_valid = ($urandom_range(0, 3) != 0);
      will = bus.data_in_valid && bus.data_in_ready;
      step(1);
      if (will) begin
        exp_q.push_back(32'h100 + WIDTH'(pushed));
        pushed++;
      end
    end
    bus.data_in_valid = 1'b0;
    chk("stream_pushed", pushed, 37);
    wait_drain(37);
    score("stream_order");
    chk("stream_max_level_ok", (max_lvl <= DEPTH), 1'b1);

    // reset mid-transfer with 3 words buffered
    auto_en = 1'b0;
    man_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.data_in = 32'hC0DE_0000 + WIDTH'(i);
      bus.data_in_valid = 1'b1;
      step(1);
    end
    bus.data_in_valid = 1'b0;
    chk("midrst_pre_level", bus.fifo_level, 3);
    chk("midrst_pre_valid", bus.data_out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid_async", bus.data_out_valid, 1'b0);
    chk("midrst_level_async", bus.fifo_level, 0);
    chk("midrst_ready_async", bus.data_in_ready, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;
    step(5);
    chk("midrst_no_launch", bus.data_out_valid, 1'b0);
    chk("midrst_state", dbg_state, ST_IDLE);
    chk("midrst_data_clear", bus.data_out, 0);
    bus.data_in = 32'h0000_BEEF;
    bus.data_in_valid = 1'b1;
    step(1);
    bus.data_in_valid = 1'b0;
    step(1);
    chk("midrst_new_valid", bus.data_out_valid, 1'b1);
    chk("midrst_new_data", bus.data_out, 32'h0000_BEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
